// File: rtl/custom_axi_ip_regs.sv
// custom_axi_ip_regs: AXI4-Lite register file that loads, starts and collects results from custom_axi_ip.
// Define CUSTOM_AXI_IP_IRQ_EN to add the IRQ_MASK register (0x18) and the irq_o output.
//
// state   | meaning
// W_IDLE  | collecting AW and W; either may arrive first and is held until the other
// W_RESP  | write applied, bvalid held until bready
// R_IDLE  | waiting for AR
// R_VALID | rdata/rresp held until rready
module custom_axi_ip_regs #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [63:0]             ipreg_data_o,
    output logic                    enable_o,
    input  logic [63:0]             ipreg_data_i,
    input  logic                    wen_i,
`ifdef CUSTOM_AXI_IP_IRQ_EN
    output logic                    irq_o,
`endif
    input  logic [1:0]              status_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_IDLE = 2'd0;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_VALID} r_state_e;

    w_state_e w_state;
    r_state_e r_state;

    logic                    aw_held, w_held;
    logic [2:0]              aw_idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0]   din_lo, din_hi, dout_lo, dout_hi;
    logic                    done, done_d;
`ifdef CUSTOM_AXI_IP_IRQ_EN
    logic                    irq_mask, irq_mask_d;
`endif

    logic                    aw_fire, w_fire, wr_commit, start_req, start_ok, w1c_done, wr_err;
    logic [2:0]              wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_err;
    logic                    unused_addr;

    assign unused_addr  = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                            s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_araddr[ADDR_WIDTH-1:5]};
    assign ipreg_data_o = {din_hi, din_lo};

    // A held beat takes priority over the live bus, which is idle for that channel anyway.
    always_comb begin
        aw_fire   = s_axi_awvalid & s_axi_awready;
        w_fire    = s_axi_wvalid & s_axi_wready;
        wr_commit = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
        wr_idx    = aw_held ? aw_idx_q : s_axi_awaddr[4:2];
        wr_data   = w_held ? wdata_q : s_axi_wdata;
        wr_strb   = w_held ? wstrb_q : s_axi_wstrb;
        start_req = wr_commit & (wr_idx == 3'd0) & wr_strb[0] & wr_data[0];
        start_ok  = start_req & (status_i == STATUS_IDLE);
        w1c_done  = wr_commit & (wr_idx == 3'd1) & wr_strb[0] & wr_data[2];
        wr_err    = 1'b0;
        case (wr_idx)
            3'd0:                 wr_err = start_req & ~start_ok;
            3'd1, 3'd2, 3'd3:     wr_err = 1'b0;
`ifdef CUSTOM_AXI_IP_IRQ_EN
            3'd6:                 wr_err = 1'b0;
`endif
            default:              wr_err = 1'b1;
        endcase
        // Result capture beats a same-cycle software clear.
        done_d = wen_i | (done & ~(w1c_done | start_ok));
`ifdef CUSTOM_AXI_IP_IRQ_EN
        irq_mask_d = (wr_commit & (wr_idx == 3'd6) & wr_strb[0]) ? wr_data[0] : irq_mask;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_commit) begin
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        s_axi_bvalid  <= 1'b1;
                        s_axi_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        w_state       <= W_RESP;
                    end else begin
                        if (aw_fire) begin
                            aw_held       <= 1'b1;
                            aw_idx_q      <= s_axi_awaddr[4:2];
                            s_axi_awready <= 1'b0;
                        end else begin
                            s_axi_awready <= ~aw_held;
                        end
                        if (w_fire) begin
                            w_held       <= 1'b1;
                            wdata_q      <= s_axi_wdata;
                            wstrb_q      <= s_axi_wstrb;
                            s_axi_wready <= 1'b0;
                        end else begin
                            s_axi_wready <= ~w_held;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            din_lo   <= '0;
            din_hi   <= '0;
            dout_lo  <= '0;
            dout_hi  <= '0;
            done     <= 1'b0;
            enable_o <= 1'b0;
`ifdef CUSTOM_AXI_IP_IRQ_EN
            irq_mask <= 1'b0;
            irq_o    <= 1'b0;
`endif
        end else begin
            enable_o <= start_ok;
            done     <= done_d;
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_commit && wr_strb[b] && wr_idx == 3'd2) din_lo[8*b +: 8] <= wr_data[8*b +: 8];
                if (wr_commit && wr_strb[b] && wr_idx == 3'd3) din_hi[8*b +: 8] <= wr_data[8*b +: 8];
            end
            if (wen_i) begin
                dout_lo <= ipreg_data_i[31:0];
                dout_hi <= ipreg_data_i[63:32];
            end
`ifdef CUSTOM_AXI_IP_IRQ_EN
            irq_mask <= irq_mask_d;
            irq_o    <= done_d & irq_mask_d;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (s_axi_araddr[4:2])
            3'd0:    rd_data = '0;
            3'd1:    rd_data = {{(DATA_WIDTH-3){1'b0}}, done, status_i};
            3'd2:    rd_data = din_lo;
            3'd3:    rd_data = din_hi;
            3'd4:    rd_data = dout_lo;
            3'd5:    rd_data = dout_hi;
`ifdef CUSTOM_AXI_IP_IRQ_EN
            3'd6:    rd_data = {{(DATA_WIDTH-1){1'b0}}, irq_mask};
`endif
            default: rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rdata   <= rd_data;
                        s_axi_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_VALID;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_VALID: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// Self-checking bench for custom_axi_ip_regs: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a register-map model.
module tb_custom_axi_ip_regs;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [5:0]  s_axi_awaddr, s_axi_araddr;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;
    logic [63:0] ipreg_data_o, ipreg_data_i;
    logic        enable_o, wen_i;
    logic [1:0]  status_i;
`ifdef CUSTOM_AXI_IP_IRQ_EN
    logic        irq_o;
`endif

    always #5 clk_i = ~clk_i;

    custom_axi_ip_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ipreg_data_o(ipreg_data_o), .enable_o(enable_o), .ipreg_data_i(ipreg_data_i),
        .wen_i(wen_i),
`ifdef CUSTOM_AXI_IP_IRQ_EN
        .irq_o(irq_o),
`endif
        .status_i(status_i)
    );

    int   n_pass = 0;
    int   n_total = 0;
    int   en_count = 0;
    logic last_en;

    always @(negedge clk_i) if (rst_ni && enable_o) en_count++;

    // Register-map model
    logic [31:0] m_din_lo, m_din_hi;
    logic [63:0] m_dout;
    logic        m_done, m_mask;

    typedef struct {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  status;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] st, input logic [31:0] er, input logic [1:0] eresp);
        vec_t v;
        v.is_wr = w; v.addr = a; v.wdata = d; v.strb = s; v.status = st;
        v.exp_rdata = er; v.exp_resp = eresp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_bus();
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_rready = 0; wen_i = 0;
        s_axi_awaddr = 0; s_axi_araddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
        ipreg_data_i = 0; status_i = 0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst_ni = 0;
        repeat (3) tick();
        rst_ni = 1;
        tick();
        m_din_lo = 0; m_din_hi = 0; m_dout = 0; m_done = 0; m_mask = 0;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done, w_done, aw_f, w_f, stable;
        int c;
        logic [1:0] first;
        aw_done = 0; w_done = 0; c = 0; resp = 2'bxx;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        while (!(aw_done && w_done) && c < 40) begin
            s_axi_awvalid = !aw_done && (c >= aw_dly);
            s_axi_wvalid  = !w_done && (c >= w_dly);
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            tick();
            aw_done |= aw_f;
            w_done  |= w_f;
            c++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        if (!(aw_done && w_done)) begin
            timeout("aw_w_handshake");
            return;
        end
        chk("bvalid_after_accept", s_axi_bvalid, 1);
        last_en = enable_o;
        first = s_axi_bresp; stable = 1;
        for (int i = 0; i < b_dly; i++) begin
            tick();
            stable &= s_axi_bvalid && (s_axi_bresp === first);
        end
        chk("b_hold_stable", stable, 1);
        resp = s_axi_bresp;
        s_axi_bready = 1; tick(); s_axi_bready = 0;
        chk("bvalid_drop", s_axi_bvalid, 0);
    endtask

    task automatic axi_read(input logic [5:0] a, input int hold, output logic [31:0] data, output logic [1:0] resp);
        bit fired, stable;
        int c;
        fired = 0; c = 0; data = 'x; resp = 'x;
        s_axi_araddr = a; s_axi_arvalid = 1;
        while (!fired && c < 40) begin
            fired = s_axi_arready;
            tick();
            c++;
        end
        s_axi_arvalid = 0;
        if (!fired) begin
            timeout("ar_handshake");
            return;
        end
        chk("rvalid_after_accept", s_axi_rvalid, 1);
        data = s_axi_rdata; resp = s_axi_rresp; stable = 1;
        for (int i = 0; i < hold; i++) begin
            tick();
            stable &= s_axi_rvalid && (s_axi_rdata === data) && (s_axi_rresp === resp);
        end
        chk("r_hold_stable", stable, 1);
        s_axi_rready = 1; tick(); s_axi_rready = 0;
        chk("rvalid_drop", s_axi_rvalid, 0);
    endtask

    task automatic pulse_wen(input logic [63:0] d);
        ipreg_data_i = d; wen_i = 1; tick(); wen_i = 0;
    endtask

    task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] st, output logic [1:0] resp, output int pulse);
        logic [31:0] bm;
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        resp = 2'b00; pulse = 0;
        case (idx)
            3'd0: if (s[0] && d[0]) begin
                      if (st == 2'd0) begin pulse = 1; m_done = 0; end
                      else resp = 2'b10;
                  end
            3'd1: if (s[0] && d[2]) m_done = 0;
            3'd2: m_din_lo = (m_din_lo & ~bm) | (d & bm);
            3'd3: m_din_hi = (m_din_hi & ~bm) | (d & bm);
`ifdef CUSTOM_AXI_IP_IRQ_EN
            3'd6: if (s[0]) m_mask = d[0];
`endif
            default: resp = 2'b10;
        endcase
    endtask

    task automatic model_read(input logic [2:0] idx, input logic [1:0] st,
                              output logic [31:0] d, output logic [1:0] resp);
        d = 0; resp = 2'b00;
        case (idx)
            3'd0: d = 0;
            3'd1: d = 32'(st) + (m_done ? 32'd4 : 32'd0);
            3'd2: d = m_din_lo;
            3'd3: d = m_din_hi;
            3'd4: d = m_dout[31:0];
            3'd5: d = m_dout[63:32];
`ifdef CUSTOM_AXI_IP_IRQ_EN
            3'd6: d = {31'd0, m_mask};
`endif
            default: resp = 2'b10;
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp, eresp;
        logic [31:0] rd, ed;
        logic [5:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [63:0] d64;
        int          e0, pulse;
        logic [1:0]  resp2;
        logic [31:0] rd2;

        // Reset state
        idle_bus();
        rst_ni = 0;
        repeat (3) tick();
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_enable", enable_o, 0);
        chk("rst_operand", ipreg_data_o, 0);
        rst_ni = 1;
        tick();
        chk("rel_awready", s_axi_awready, 1);
        chk("rel_wready", s_axi_wready, 1);
        chk("rel_arready", s_axi_arready, 1);

        // AW and W together, then W three cycles ahead of AW with partial strobes
        axi_write(6'h08, 32'h1234_5678, 4'hF, 0, 0, 0, resp);
        chk("din_lo_bresp", resp, 2'b00);
        chk("din_lo_operand", ipreg_data_o[31:0], 32'h1234_5678);
        axi_write(6'h0C, 32'hA5A5_0000, 4'b1100, 3, 0, 1, resp);
        chk("din_hi_bresp", resp, 2'b00);
        chk("din_hi_operand", ipreg_data_o[63:32], 32'hA5A5_0000);

        add_vec(0, 6'h08, 0, 0, 0, 32'h1234_5678, 2'b00);
        add_vec(0, 6'h0C, 0, 0, 0, 32'hA5A5_0000, 2'b00);
        add_vec(1, 6'h08, 32'hFFFF_FFFF, 4'b0001, 0, 0, 2'b00);
        add_vec(0, 6'h08, 0, 0, 0, 32'h1234_56FF, 2'b00);
        add_vec(1, 6'h0C, 32'h0000_BEEF, 4'b0011, 0, 0, 2'b00);
        add_vec(0, 6'h2C, 0, 0, 0, 32'hA5A5_BEEF, 2'b00);
        add_vec(0, 6'h0B, 0, 0, 0, 32'h1234_56FF, 2'b00);
        add_vec(0, 6'h00, 0, 0, 0, 32'h0, 2'b00);
        add_vec(0, 6'h04, 0, 0, 2, 32'h2, 2'b00);
        add_vec(0, 6'h04, 0, 0, 3, 32'h3, 2'b00);
        add_vec(1, 6'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b10);
        add_vec(1, 6'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b10);
        add_vec(1, 6'h1C, 32'h1, 4'hF, 0, 0, 2'b10);
        add_vec(0, 6'h1C, 0, 0, 0, 32'h0, 2'b10);
        add_vec(0, 6'h10, 0, 0, 0, 32'h0, 2'b00);
`ifdef CUSTOM_AXI_IP_IRQ_EN
        add_vec(0, 6'h18, 0, 0, 0, 32'h0, 2'b00);
`else
        add_vec(0, 6'h18, 0, 0, 0, 32'h0, 2'b10);
        add_vec(1, 6'h18, 32'h1, 4'hF, 0, 0, 2'b10);
`endif
        add_vec(1, 6'h04, 32'h4, 4'h1, 0, 0, 2'b00);
        add_vec(1, 6'h00, 32'h0, 4'hF, 0, 0, 2'b00);
        add_vec(1, 6'h00, 32'h1, 4'hF, 1, 0, 2'b10);

        foreach (vecs[i]) begin
            status_i = vecs[i].status;
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, 0, 0, resp);
                chk($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, 0, rd, resp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                chk($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end
        status_i = 0;
        chk("table_operand", ipreg_data_o, 64'hA5A5_BEEF_1234_56FF);

        // START: single pulse when idle, rejected when busy or strobe-masked
        e0 = en_count;
        axi_write(6'h00, 32'h1, 4'h1, 0, 0, 0, resp);
        chk("start_idle_bresp", resp, 2'b00);
        chk("start_idle_en_at_commit", last_en, 1);
        tick(); tick();
        chk("start_idle_pulses", en_count - e0, 1);
        status_i = 1;
        e0 = en_count;
        axi_write(6'h00, 32'h1, 4'hF, 0, 0, 0, resp);
        chk("start_busy_bresp", resp, 2'b10);
        tick();
        chk("start_busy_pulses", en_count - e0, 0);
        status_i = 0;
        e0 = en_count;
        axi_write(6'h00, 32'h1, 4'hE, 0, 0, 0, resp);
        tick();
        chk("start_nostrb_pulses", en_count - e0, 0);

        // Result capture, DONE clear by START and by W1C
        pulse_wen(64'h0000_0002_0000_0003);
        axi_read(6'h10, 0, rd, resp);
        chk("dout_lo", rd, 32'h3);
        axi_read(6'h14, 0, rd, resp);
        chk("dout_hi", rd, 32'h2);
        axi_read(6'h04, 0, rd, resp);
        chk("done_set", rd, 32'h4);
        axi_write(6'h00, 32'h1, 4'h1, 0, 0, 0, resp);
        axi_read(6'h04, 0, rd, resp);
        chk("done_cleared_by_start", rd, 32'h0);

        // W1C committing in the same cycle as wen_i: set wins
        s_axi_awaddr = 6'h04; s_axi_wdata = 32'h4; s_axi_wstrb = 4'h1;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        ipreg_data_i = 64'h0000_0007_0000_0009; wen_i = 1;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0; wen_i = 0;
        chk("w1c_race_bvalid", s_axi_bvalid, 1);
        s_axi_bready = 1; tick(); s_axi_bready = 0;
        axi_read(6'h04, 0, rd, resp);
        chk("w1c_race_done", rd, 32'h4);

        // Write to RO leaves DOUT alone; long rready stall keeps rdata stable
        axi_write(6'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
        chk("ro_bresp", resp, 2'b10);
        axi_read(6'h10, 5, rd, resp);
        chk("ro_dout_kept", rd, 32'h9);

        // Concurrent read and write
        fork
            axi_write(6'h08, 32'h1111_1111, 4'hF, 0, 0, 0, resp);
            axi_read(6'h0C, 0, rd2, resp2);
        join
        chk("conc_bresp", resp, 2'b00);
        chk("conc_rdata", rd2, 32'hA5A5_BEEF);
        chk("conc_operand", ipreg_data_o[31:0], 32'h1111_1111);

`ifdef CUSTOM_AXI_IP_IRQ_EN
        axi_write(6'h04, 32'h4, 4'h1, 0, 0, 0, resp);
        axi_write(6'h18, 32'h1, 4'h1, 0, 0, 0, resp);
        chk("mask_bresp", resp, 2'b00);
        axi_read(6'h18, 0, rd, resp);
        chk("mask_read", rd, 32'h1);
        chk("irq_low_before", irq_o, 0);
        pulse_wen(64'h5);
        chk("irq_after_wen", irq_o, 1);
        axi_write(6'h04, 32'h4, 4'h1, 0, 0, 0, resp);
        chk("irq_after_w1c", irq_o, 0);
`endif

        // Reset with AW held drops the transaction
        s_axi_awaddr = 6'h08; s_axi_awvalid = 1;
        tick();
        s_axi_awvalid = 0;
        rst_ni = 0;
        tick();
        chk("midrst_bvalid", s_axi_bvalid, 0);
        chk("midrst_awready", s_axi_awready, 0);
        chk("midrst_operand", ipreg_data_o, 0);
        rst_ni = 1;
        tick();
        chk("midrst_rel_awready", s_axi_awready, 1);
        s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
        tick();
        s_axi_wvalid = 0;
        tick(); tick();
        chk("midrst_no_response", s_axi_bvalid, 0);
        chk("midrst_no_update", ipreg_data_o, 0);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            int op;
            op = $urandom_range(0, 9);
            status_i = 2'($urandom_range(0, 3));
            if (op < 4) begin
                a = 6'($urandom);
                if (op == 3) a[4:2] = 3'($urandom_range(0, 1));
                d = $urandom;
                s = 4'($urandom);
                model_write(a[4:2], d, s, status_i, eresp, pulse);
                e0 = en_count;
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
                chk($sformatf("rnd%0d_bresp", k), resp, eresp);
                chk($sformatf("rnd%0d_start_pulses", k), en_count - e0, pulse);
            end else if (op < 8) begin
                a = 6'($urandom);
                model_read(a[4:2], status_i, ed, eresp);
                axi_read(a, $urandom_range(0, 2), rd, resp);
                chk($sformatf("rnd%0d_rdata", k), rd, ed);
                chk($sformatf("rnd%0d_rresp", k), resp, eresp);
            end else begin
                d64 = {$urandom, $urandom};
                pulse_wen(d64);
                m_dout = d64;
                m_done = 1;
            end
            chk($sformatf("rnd%0d_operand", k), ipreg_data_o, {m_din_hi, m_din_lo});
`ifdef CUSTOM_AXI_IP_IRQ_EN
            chk($sformatf("rnd%0d_irq", k), irq_o, m_done & m_mask);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
